// File: rtl/ad9228_serializer_tx.sv
// rtl/ad9228_serializer_tx.sv - AD9228-format 12:8 transmit gearbox with input FIFO and FCO slice generation
// Optional ramp/checkerboard/idle pattern source is built in when AD9228_TX_TEST_PATTERN_EN is defined.
module ad9228_serializer_tx #(
    parameter int          DATA_WIDTH = 12,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] IDLE_WORD  = 12'h800
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [7:0]            data_out,
    output logic [7:0]            fco_out,
    output logic [1:0]            phase_out,
    output logic                  underflow,
    output logic                  underflow_sticky,
`ifdef AD9228_TX_TEST_PATTERN_EN
    input  logic [1:0]            pattern_sel,
`endif
    input  logic                  clr_sticky
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    generate
        if (DATA_WIDTH != 12) begin : g_bad_width
            $error("ad9228_serializer_tx: DATA_WIDTH must be 12");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ad9228_serializer_tx: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} phase_e;

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    phase_e        phase_q, phase_d;
    logic [7:0]    data_q, data_d, fco_q, fco_d, residue_q, residue_d;
    logic [1:0]    phase_out_q, phase_out_d;
    logic          uf_q, uf_d, sticky_q, sticky_d;
    logic          push, fifo_pop, slot;
    logic [11:0]   word;
    logic          pattern_on;
    logic [11:0]   pattern_word;

    assign s_ready = (count_q < DEPTH_C);
    assign push    = s_valid && s_ready;
    assign slot    = enable && (phase_q != PH2);

`ifdef AD9228_TX_TEST_PATTERN_EN
    logic [1:0]  sel_q, sel_cur;
    logic [11:0] ramp_q;
    logic        chk_q;

    // The source is only re-chosen at a phase-0 pop so words A and B of a pair never mix sources.
    assign sel_cur    = (phase_q == PH0) ? pattern_sel : sel_q;
    assign pattern_on = (sel_cur != 2'd0);

    always_comb begin
        unique case (sel_cur)
            2'd1:    pattern_word = ramp_q;
            2'd2:    pattern_word = chk_q ? 12'h555 : 12'hAAA;
            default: pattern_word = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q  <= 2'd0;
            ramp_q <= 12'd0;
            chk_q  <= 1'b0;
        end else if (slot) begin
            if (phase_q == PH0) sel_q <= pattern_sel;
            if (sel_cur == 2'd1) ramp_q <= ramp_q + 12'd1;
            if (sel_cur == 2'd2) chk_q <= ~chk_q;
        end
    end
`else
    assign pattern_on   = 1'b0;
    assign pattern_word = IDLE_WORD;
`endif

    always_comb begin
        phase_d     = PH0;
        data_d      = 8'h00;
        fco_d       = 8'h00;
        phase_out_d = 2'd0;
        residue_d   = residue_q;
        word        = IDLE_WORD;
        fifo_pop    = 1'b0;
        uf_d        = 1'b0;
        if (enable) begin
            unique case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                default: phase_d = PH0;
            endcase
            if (slot) begin
                if (pattern_on) begin
                    word = pattern_word;
                end else if (count_q == '0) begin
                    uf_d = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                    word     = mem_q[rd_ptr_q];
                end
            end
            // Two 12-bit words spread over three 8-bit slices; residue carries the leftover bits.
            unique case (phase_q)
                PH0: begin
                    data_d    = word[11:4];
                    fco_d     = 8'hFC;
                    residue_d = {4'h0, word[3:0]};
                end
                PH1: begin
                    data_d    = {residue_q[3:0], word[11:8]};
                    fco_d     = 8'h0F;
                    residue_d = word[7:0];
                end
                default: begin
                    data_d = residue_q;
                    fco_d  = 8'hC0;
                end
            endcase
            phase_out_d = phase_q;
        end
    end

    always_comb begin
        wr_ptr_d = push     ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !fifo_pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push && fifo_pop) count_d = count_q - (AW + 1)'(1);
        // A new underflow wins over a simultaneous clear.
        sticky_d = uf_d ? 1'b1 : (clr_sticky ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            phase_q     <= PH0;
            data_q      <= 8'h00;
            fco_q       <= 8'h00;
            phase_out_q <= 2'd0;
            residue_q   <= 8'h00;
            uf_q        <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            data_q      <= data_d;
            fco_q       <= fco_d;
            phase_out_q <= phase_out_d;
            residue_q   <= residue_d;
            uf_q        <= uf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign data_out         = data_q;
    assign fco_out          = fco_q;
    assign phase_out        = phase_out_q;
    assign underflow        = uf_q;
    assign underflow_sticky = sticky_q;

endmodule

// File: tb/tb_ad9228_serializer_tx.sv
// tb/tb_ad9228_serializer_tx.sv - scoreboard testbench for the AD9228 transmit gearbox
module tb_ad9228_serializer_tx;
    logic        clk = 1'b0, rstn = 1'b0, enable = 1'b0, s_valid = 1'b0, clr_sticky = 1'b0;
    logic [11:0] s_data = 12'h000;
    logic        s_ready, underflow, underflow_sticky;
    logic [7:0]  data_out, fco_out;
    logic [1:0]  phase_out;
`ifdef AD9228_TX_TEST_PATTERN_EN
    logic [1:0]  pattern_sel = 2'd0;
`endif
    int          tests = 0, fails = 0;
    logic [11:0] sb_q [$];

    always #5 clk = ~clk;

    ad9228_serializer_tx dut (
        .clk(clk), .rstn(rstn), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_out(data_out), .fco_out(fco_out), .phase_out(phase_out),
        .underflow(underflow), .underflow_sticky(underflow_sticky),
`ifdef AD9228_TX_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .clr_sticky(clr_sticky)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [11:0] w);
        logic acc;
        acc = s_ready;
        s_valid = 1'b1;
        s_data = w;
        step();
        s_valid = 1'b0;
        if (acc) sb_q.push_back(w);
    endtask

    function automatic logic [11:0] sb_pop();
        if (sb_q.size() == 0) return 12'hxxx;
        return sb_q.pop_front();
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        step(); step();
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_out); end
        tests++; if (fco_out !== 8'h00) begin fails++; $display("FAIL reset_fco: got %h want 00", fco_out); end
        tests++; if (phase_out !== 2'd0) begin fails++; $display("FAIL reset_phase: got %0d want 0", phase_out); end
        tests++; if (underflow !== 1'b0 || underflow_sticky !== 1'b0) begin fails++; $display("FAIL reset_uf: got %b%b want 00", underflow, underflow_sticky); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0]  ed [3] = '{8'hAB, 8'hC1, 8'h23};
        logic [7:0]  ef [3] = '{8'hFC, 8'h0F, 8'hC0};
        logic [7:0]  sd [3];
        logic [11:0] e;
        push_word(12'hABC);
        push_word(12'h123);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            sd[i] = data_out;
            tests++; if (data_out !== ed[i]) begin fails++; $display("FAIL basic_data[%0d]: got %h want %h", i, data_out, ed[i]); end
            tests++; if (fco_out !== ef[i]) begin fails++; $display("FAIL basic_fco[%0d]: got %h want %h", i, fco_out, ef[i]); end
            tests++; if (phase_out !== 2'(i)) begin fails++; $display("FAIL basic_phase[%0d]: got %0d want %0d", i, phase_out, i); end
        end
        enable = 1'b0;
        step();
        tests++; if (data_out !== 8'h00 || fco_out !== 8'h00) begin fails++; $display("FAIL basic_disabled: got %h/%h want 00/00", data_out, fco_out); end
        e = sb_pop();
        tests++; if ({sd[0], sd[1][7:4]} !== e) begin fails++; $display("FAIL basic_wordA: got %h want %h", {sd[0], sd[1][7:4]}, e); end
        e = sb_pop();
        tests++; if ({sd[1][3:0], sd[2]} !== e) begin fails++; $display("FAIL basic_wordB: got %h want %h", {sd[1][3:0], sd[2]}, e); end
    endtask

    task automatic test_underflow();
        logic [7:0] ed [3] = '{8'h80, 8'h08, 8'h00};
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++; if (data_out !== ed[i % 3]) begin fails++; $display("FAIL uf_data[%0d]: got %h want %h", i, data_out, ed[i % 3]); end
            tests++; if (underflow !== (i % 3 != 2)) begin fails++; $display("FAIL uf_pulse[%0d]: got %b want %b", i, underflow, (i % 3 != 2)); end
        end
        tests++; if (underflow_sticky !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b want 1", underflow_sticky); end
        clr_sticky = 1'b1;
        step();
        tests++; if (underflow_sticky !== 1'b1) begin fails++; $display("FAIL uf_sticky_conflict: got %b want 1", underflow_sticky); end
        enable = 1'b0;
        step();
        clr_sticky = 1'b0;
        tests++; if (underflow_sticky !== 1'b0) begin fails++; $display("FAIL uf_sticky_clear: got %b want 0", underflow_sticky); end
    endtask

    task automatic test_ramp();
        int          idx = 0, nrecon = 0, rdy_cnt = 0, cyc = 0, ph = 0;
        logic        r;
        logic [7:0]  s0 = 8'h00, s1 = 8'h00;
        logic [11:0] e;
        s_valid = 1'b1;
        s_data = 12'h000;
        while (nrecon < 100 && cyc < 400) begin
            r = s_valid && s_ready;
            if (cyc == 6) enable = 1'b1;
            if (cyc >= 20 && cyc < 50 && s_ready) rdy_cnt++;
            step();
            cyc++;
            if (r) begin
                sb_q.push_back(idx[11:0]);
                idx++;
                if (idx == 100) s_valid = 1'b0;
                else s_data = idx[11:0];
            end
            if (fco_out !== 8'h00) begin
                tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL ramp_underflow: got %b want 0 at word %0d", underflow, nrecon); end
                tests++; if (phase_out !== 2'(ph)) begin fails++; $display("FAIL ramp_phase: got %0d want %0d", phase_out, ph); end
                if (ph == 0) s0 = data_out;
                else if (ph == 1) begin
                    s1 = data_out;
                    e = sb_pop();
                    tests++; if ({s0, s1[7:4]} !== e) begin fails++; $display("FAIL ramp_word: got %h want %h", {s0, s1[7:4]}, e); end
                    nrecon++;
                end else begin
                    e = sb_pop();
                    tests++; if ({s1[3:0], data_out} !== e) begin fails++; $display("FAIL ramp_word: got %h want %h", {s1[3:0], data_out}, e); end
                    nrecon++;
                end
                ph = (ph == 2) ? 0 : ph + 1;
            end
        end
        s_valid = 1'b0;
        enable = 1'b0;
        step();
        tests++; if (nrecon != 100) begin fails++; $display("FAIL ramp_count: got %0d want 100", nrecon); end
        tests++; if (rdy_cnt != 20) begin fails++; $display("FAIL ramp_throttle: got %0d want 20 of 30", rdy_cnt); end
    endtask

    task automatic test_full();
        logic [11:0] w [4] = '{12'h9E1, 12'h246, 12'hD7B, 12'h5C0};
        logic [7:0]  sl [3];
        logic [11:0] e;
        for (int i = 0; i < 4; i++) push_word(w[i]);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", s_ready); end
        enable = 1'b1;
        s_valid = 1'b1;
        s_data = 12'hFFF;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                if (p == 0 && k == 0) begin
                    s_valid = 1'b0;
                    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL full_reject_ready: got %b want 1", s_ready); end
                end
                sl[k] = data_out;
            end
            e = sb_pop();
            tests++; if ({sl[0], sl[1][7:4]} !== e) begin fails++; $display("FAIL full_wordA[%0d]: got %h want %h", p, {sl[0], sl[1][7:4]}, e); end
            e = sb_pop();
            tests++; if ({sl[1][3:0], sl[2]} !== e) begin fails++; $display("FAIL full_wordB[%0d]: got %h want %h", p, {sl[1][3:0], sl[2]}, e); end
        end
        step();
        tests++; if (underflow !== 1'b1 || data_out !== 8'h80) begin fails++; $display("FAIL full_rejected_absent: got uf=%b data=%h want uf=1 data=80", underflow, data_out); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reenable();
        logic [11:0] w [4];
        logic [7:0]  a, b;
        push_word(12'h3A7); push_word(12'h6B2); push_word(12'hE49); push_word(12'h08D);
        for (int i = 0; i < 4; i++) w[i] = sb_pop();
        enable = 1'b1;
        step(); a = data_out;
        step(); b = data_out;
        tests++; if ({a, b} !== {w[0][11:0], w[1][11:8]}) begin fails++; $display("FAIL reen_first: got %h want %h", {a, b}, {w[0], w[1][11:8]}); end
        enable = 1'b0;
        step();
        tests++; if (data_out !== 8'h00 || fco_out !== 8'h00 || phase_out !== 2'd0) begin fails++; $display("FAIL reen_off: got %h/%h/%0d want 00/00/0", data_out, fco_out, phase_out); end
        enable = 1'b1;
        step();
        tests++; if (data_out !== w[2][11:4] || fco_out !== 8'hFC || phase_out !== 2'd0) begin fails++; $display("FAIL reen_phase0: got %h/%h/%0d want %h/FC/0", data_out, fco_out, phase_out, w[2][11:4]); end
        step();
        tests++; if (data_out !== {w[2][3:0], w[3][11:8]}) begin fails++; $display("FAIL reen_phase1: got %h want %h", data_out, {w[2][3:0], w[3][11:8]}); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        push_word(12'h5A5); push_word(12'hA5A);
        enable = 1'b1;
        step();
        rstn = 1'b0;
        #1;
        tests++; if (data_out !== 8'h00 || fco_out !== 8'h00 || s_ready !== 1'b1 || underflow_sticky !== 1'b0) begin fails++; $display("FAIL rstmid_async: got %h/%h/%b/%b want 00/00/1/0", data_out, fco_out, s_ready, underflow_sticky); end
        #1;
        rstn = 1'b1;
        sb_q.delete();
        step();
        tests++; if (data_out !== 8'h80 || underflow !== 1'b1 || phase_out !== 2'd0) begin fails++; $display("FAIL rstmid_flush: got %h/%b/%0d want 80/1/0", data_out, underflow, phase_out); end
        enable = 1'b0;
        step();
    endtask

`ifdef AD9228_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [7:0]  ed [3] = '{8'hAA, 8'hA5, 8'h55};
        logic [7:0]  sl [3];
        logic [11:0] e;
        push_word(12'h7E1); push_word(12'h18C);
        pattern_sel = 2'd2;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++; if (data_out !== ed[i % 3] || underflow !== 1'b0) begin fails++; $display("FAIL pat_checker[%0d]: got %h/%b want %h/0", i, data_out, underflow, ed[i % 3]); end
        end
        enable = 1'b0;
        pattern_sel = 2'd0;
        step();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin step(); sl[k] = data_out; end
        e = sb_pop();
        tests++; if ({sl[0], sl[1][7:4]} !== e) begin fails++; $display("FAIL pat_fifo_wordA: got %h want %h", {sl[0], sl[1][7:4]}, e); end
        e = sb_pop();
        tests++; if ({sl[1][3:0], sl[2]} !== e) begin fails++; $display("FAIL pat_fifo_wordB: got %h want %h", {sl[1][3:0], sl[2]}, e); end
        enable = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_ramp();
        test_full();
        test_reenable();
        test_reset_mid();
`ifdef AD9228_TX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ad9228_serializer_tx.md
Name: ad9228_serializer_tx

Overview:
- Transmit-side 12:8 gearbox that produces an AD9228-format LVDS lane stream for loopback and emulation of the ADC receive path.
- Accepts 12-bit samples through a valid/ready handshake in the parallel-clock domain. Each clock it emits one 8-bit data slice and the matching 8-bit frame-clock (FCO) slice.
- Both slices feed downstream 8:1 DDR output serializers. Serial rates: 2 bits per DCO cycle, FCO = DCO/6, parallel clock = DCO/4.

Parameters:
- DATA_WIDTH, 12, sample width; only 12 is supported, and an elaboration-time error is raised otherwise.
- FIFO_DEPTH, 4, input FIFO depth in words; must be a power of 2 and at least 2.
- IDLE_WORD, 12'h800, word inserted when the FIFO underflows (mid-scale, offset binary).

Ports:
- clk  in  1  parallel clock (DCO/4); all logic is on posedge.
- rstn  in  1  Reset rstn, asynchronous, active-low.
- enable  in  1  stream enable.
- s_data  in  12  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO can accept a sample.
- data_out  out  8  serial data slice; bit 7 is transmitted first (MSB-first word order).
- fco_out  out  8  FCO slice, bit-aligned with data_out.
- phase_out  out  2  phase (0..2) of the slice currently on data_out.
- underflow  out  1  one-cycle pulse when IDLE_WORD is substituted.
- underflow_sticky  out  1  set on any underflow; cleared by clr_sticky.
- clr_sticky  in  1  clears underflow_sticky.

Behaviour:
- Reset values: data_out=0, fco_out=0, phase_out=0, underflow=0, underflow_sticky=0, FIFO empty, internal phase counter=0, residue register=0.
- s_ready = (fifo_count < FIFO_DEPTH), combinational from count.
- Push happens when s_valid && s_ready. A pushed word is poppable no earlier than the next cycle.
- Phase counter runs 0,1,2,0 and advances every clk while enable=1. When enable=0 it is forced to 0.
- Pops occur in the cycle the phase counter is 0 (word A) and the cycle it is 1 (word B). No pop occurs in phase 2. This gives exactly 2 words per 3 clks.
- Output register, loaded at the posedge that ends the cycle:
  - phase 0: data_out=A[11:4]; fco_out=8'hFC; residue<=A[3:0].
  - phase 1: data_out={residue, B[11:8]}; fco_out=8'h0F; residue<=B[7:0].
  - phase 2: data_out=residue[7:0]; fco_out=8'hC0.
  - phase_out is registered alongside and equals the phase of the slice it accompanies.
- The concatenated FCO pattern gives exactly 6 bit-times high and 6 low per word, with the high time starting at the word's MSB.
- Underflow: if the FIFO is empty at a pop, IDLE_WORD is used in place of the word, underflow pulses 1 cycle, and underflow_sticky is set.
- Push and pop in the same cycle: both take effect and the count is unchanged. When full, no push is possible because s_ready=0, even if a pop occurs that cycle.
- Sticky conflict: if clr_sticky and a new underflow occur in the same cycle, the sticky bit ends set.
- enable low:
  - No pops; FIFO contents retained; pushes still allowed.
  - Output register loads data_out=0 and fco_out=0 at each posedge.
  - phase_out=0 and the residue register is held.
- enable deasserted mid-frame: any partially sent word B is discarded (its residue is abandoned).
- enable rising: the first posedge with enable=1 outputs a phase-0 slice. Latency from enable sampled high to the first valid slice is 1 clk.
- Latency from push to its first slice is at least 2 clks (FIFO write, then pop with the output register load).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-stream: all state returns to reset values immediately, including flushing the FIFO and residue.

Optional Feature:
- Macro: AD9228_TX_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (2 bits): 0=FIFO data, 1=ramp (12-bit counter, incremented per consumed word, reset 0, wraps 4095->0), 2=checkerboard (alternating 12'hAAA and 12'h555, starting 12'hAAA), 3=constant IDLE_WORD.
  - For pattern_sel!=0, a pattern word replaces each pop. The FIFO is not popped and underflow never fires.
  - pattern_sel changes take effect at the next phase-0 pop only.
- When undefined: the port is absent and behaviour is as for pattern_sel=0.

Test Plan:
- Reset, then push 12'hABC and 12'h123, then raise enable -> slices (data,fco,phase) = (8'hAB,8'hFC,0), (8'hC1,8'h0F,1), (8'h23,8'hC0,2).
- enable=1 with FIFO empty -> data_out sequence 8'h80, 8'h08, 8'h00 repeating; underflow pulses in phase-0 and phase-1 cycles; sticky=1 until clr_sticky.
- Continuously push a ramp 0..99 with s_valid=1 -> s_ready throttles to 2 of every 3 cycles at steady state; the 12-bit words reconstructed from the data stream equal 0..99 with no underflow.
- Fill FIFO to 4 with enable=0 -> s_ready=0. Then s_valid with a simultaneous pop -> push rejected and count=3 afterwards.
- Drop enable after a phase-1 slice, then re-enable -> next slice is phase 0 with fco_out=8'hFC carrying the next FIFO word; the remainder of the abandoned word B is not sent.
- Macro defined, pattern_sel=2 -> data stream 8'hAA, 8'hA5, 8'h55 repeating; FIFO count unchanged.
